// File: rtl/gemm_result_drain.sv
// -----------------------------------------------------------------------------
// gemm_result_drain
//
// Captures one N x N accumulator tile, streamed column by column from a
// systolic array. It then drains the tile row by row through a valid/ready
// port. Each row is requantized on the way out: signed multiply by an
// unsigned scale, round-half-up arithmetic right shift, optional ReLU, and
// saturation to OUT_WIDTH.
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   result_in     one tile column, lane r = C[r][col], signed ACC_WIDTH each
//   result_valid  column beat valid (columns 0..N-1 in order, not stallable)
//   cfg_scale     unsigned requantization multiplier
//   cfg_shift     right-shift amount (values above 47 act as 47)
//   cfg_relu      clamp negative results to zero
//   out_data      one requantized row, lane j = C[row][j]
//   out_row       row index of out_data
//   out_valid     row valid
//   out_ready     downstream accept
//   busy          high whenever the block is not idle
//   overflow_err  sticky: a column beat arrived while draining and was dropped
//   clr_err       synchronous clear of overflow_err
// -----------------------------------------------------------------------------
module gemm_result_drain #(
  parameter int ARRAY_SIZE  = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int SCALE_WIDTH = 16,
  localparam int ROW_W      = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0] result_in,
  input  logic                            result_valid,
  input  logic [SCALE_WIDTH-1:0]          cfg_scale,
  input  logic [5:0]                      cfg_shift,
  input  logic                            cfg_relu,
  output logic [ARRAY_SIZE*OUT_WIDTH-1:0] out_data,
  output logic [ROW_W-1:0]                out_row,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            overflow_err,
  input  logic                            clr_err
);

  // The product width leaves headroom for the rounding addend. A signed
  // ACC_WIDTH value times an unsigned SCALE_WIDTH value always fits.
  localparam int PROD_W = ACC_WIDTH + SCALE_WIDTH + 1;
  localparam logic [ROW_W-1:0] LAST_IDX = ROW_W'(ARRAY_SIZE - 1);
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    LOAD,
    DRAIN
  } state_e;

  state_e                          state_q, state_d;
  logic [ROW_W-1:0]                col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0]                out_row_q, out_row_d;
  logic                            out_valid_q, out_valid_d;
  logic [ARRAY_SIZE*OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [SCALE_WIDTH-1:0]          scale_q, scale_d;
  logic [5:0]                      shift_q, shift_d;
  logic                            relu_q, relu_d;
  logic                            err_q, err_d;

  logic                            tile_we;
  logic [ROW_W-1:0]                wr_col;
  logic [ROW_W-1:0]                load_row;
  logic [ARRAY_SIZE*OUT_WIDTH-1:0] row_req;

  // tile_q[row][col]
  logic [ACC_WIDTH-1:0] tile_q [ARRAY_SIZE][ARRAY_SIZE];

  // ---------------------------------------------------------------------------
  // Requantization of one accumulator value.
  // ---------------------------------------------------------------------------
  function automatic logic [OUT_WIDTH-1:0] requant(
    input logic [ACC_WIDTH-1:0]   acc,
    input logic [SCALE_WIDTH-1:0] scale,
    input logic [5:0]             shift,
    input logic                   relu
  );
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] rnd;
    logic signed [PROD_W-1:0] sum;
    logic signed [PROD_W-1:0] shd;
    logic [5:0]               sh;
    logic [OUT_WIDTH-1:0]     res;
    sh   = (shift > 6'd47) ? 6'd47 : shift;
    prod = $signed({{(PROD_W - ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc}) *
           $signed({{(PROD_W - SCALE_WIDTH){1'b0}}, scale});
    rnd  = '0;
    if (sh != 6'd0) rnd = PROD_W'(1) << (sh - 6'd1);
    sum  = prod + rnd;
    shd  = sum >>> sh;
    if (relu && shd[PROD_W-1]) shd = '0;
    if (shd > SAT_MAX)      res = SAT_MAX[OUT_WIDTH-1:0];
    else if (shd < SAT_MIN) res = SAT_MIN[OUT_WIDTH-1:0];
    else                    res = shd[OUT_WIDTH-1:0];
    return res;
  endfunction

  // One requantized row, selected by load_row, ready to be registered.
  always_comb begin
    row_req = '0;
    for (int j = 0; j < ARRAY_SIZE; j++) begin
      row_req[j*OUT_WIDTH +: OUT_WIDTH] = requant(tile_q[load_row][j], scale_q, shift_q, relu_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath control.
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case statement. No path
  // leaves a signal unassigned, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    out_row_d   = out_row_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    scale_d     = scale_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    err_d       = err_q & ~clr_err;
    tile_we     = 1'b0;
    wr_col      = '0;
    load_row    = '0;

    unique case (state_q)
      IDLE: begin
        if (result_valid) begin
          tile_we   = 1'b1;
          wr_col    = '0;
          col_cnt_d = ROW_W'(1);
          scale_d   = cfg_scale;
          shift_d   = cfg_shift;
          relu_d    = cfg_relu;
          state_d   = (ARRAY_SIZE == 1) ? LOAD : CAPTURE;
        end
      end

      CAPTURE: begin
        if (result_valid) begin
          tile_we = 1'b1;
          wr_col  = col_cnt_q;
          if (col_cnt_q == LAST_IDX) begin
            col_cnt_d = '0;
            state_d   = LOAD;
          end else begin
            col_cnt_d = col_cnt_q + ROW_W'(1);
          end
        end
      end

      LOAD: begin
        load_row    = '0;
        out_data_d  = row_req;
        out_row_d   = '0;
        out_valid_d = 1'b1;
        state_d     = DRAIN;
      end

      DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (out_row_q == LAST_IDX) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            // The next row is registered on the same edge as the handshake,
            // so rows leave back-to-back.
            load_row   = out_row_q + ROW_W'(1);
            out_data_d = row_req;
            out_row_d  = out_row_q + ROW_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // The array cannot be stalled. A beat seen while the tile is being read
    // out is lost. Setting the flag wins over a clear in the same cycle.
    if (result_valid && (state_q == LOAD || state_q == DRAIN)) err_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Control and output registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments only. Every register
  // then samples the pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_cnt_q   <= '0;
      out_row_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      scale_q     <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      out_row_q   <= out_row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      scale_q     <= scale_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      err_q       <= err_d;
    end
  end

  // NOTE: the tile buffer has no reset. A new tile always overwrites every
  // column before any row of that tile is read, so reset values would never
  // be observed. Leaving the reset out keeps it a plain register array or RAM.
  always_ff @(posedge clk) begin
    if (tile_we) begin
      for (int r = 0; r < ARRAY_SIZE; r++) begin
        tile_q[r][wr_col] <= result_in[r*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  assign out_data     = out_data_q;
  assign out_row      = out_row_q;
  assign out_valid    = out_valid_q;
  assign busy         = (state_q != IDLE);
  assign overflow_err = err_q;

endmodule

// File: tb/tb_gemm_result_drain.sv
// -----------------------------------------------------------------------------
// tb_gemm_result_drain
//
// Directed bench for gemm_result_drain at default parameters (16x16 tile,
// 32-bit accumulators, 8-bit outputs). Every expected row is either a
// hand-derived constant or the clamped identity pattern min(r*16+c, 127).
// -----------------------------------------------------------------------------
module tb_gemm_result_drain;

  localparam int N  = 16;
  localparam int AW = 32;
  localparam int OW = 8;
  localparam int SW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*AW-1:0] result_in;
  logic            result_valid;
  logic [SW-1:0]   cfg_scale;
  logic [5:0]      cfg_shift;
  logic            cfg_relu;
  logic [N*OW-1:0] out_data;
  logic [3:0]      out_row;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            overflow_err;
  logic            clr_err;

  int n_checks = 0;
  int n_pass   = 0;

  gemm_result_drain #(
    .ARRAY_SIZE (N),
    .ACC_WIDTH  (AW),
    .OUT_WIDTH  (OW),
    .SCALE_WIDTH(SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .result_in   (result_in),
    .result_valid(result_valid),
    .cfg_scale   (cfg_scale),
    .cfg_shift   (cfg_shift),
    .cfg_relu    (cfg_relu),
    .out_data    (out_data),
    .out_row     (out_row),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .overflow_err(overflow_err),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] exp_row(input bit identity, input int r, input logic [7:0] cval);
    logic [127:0] e;
    int v;
    e = '0;
    for (int j = 0; j < N; j++) begin
      v = r * 16 + j;
      if (v > 127) v = 127;
      e[j*OW +: OW] = identity ? 8'(v) : cval;
    end
    return e;
  endfunction

  // Streams a full tile. The cfg inputs are changed after the first beat to
  // prove they were latched. The latency to the first row is checked at the end.
  task automatic send_tile(input bit identity, input logic signed [31:0] val,
                           input logic [15:0] scale, input logic [5:0] shift,
                           input bit relu, input int gap);
    cfg_scale = scale;
    cfg_shift = shift;
    cfg_relu  = relu;
    for (int c = 0; c < N; c++) begin
      for (int r = 0; r < N; r++) begin
        result_in[r*AW +: AW] = identity ? 32'(r * 16 + c) : val;
      end
      result_valid = 1'b1;
      tick;
      result_valid = 1'b0;
      if (c == 0) begin
        cfg_scale = 16'd7;
        cfg_shift = 6'd1;
        cfg_relu  = ~relu;
      end
      if (c != N - 1) repeat (gap) tick;
    end
    check("lat_load_valid", 128'(out_valid), 128'd0);
    check("lat_load_busy", 128'(busy), 128'd1);
    tick;
    check("lat_first_valid", 128'(out_valid), 128'd1);
    check("lat_first_row", 128'(out_row), 128'd0);
  endtask

  // Accepts rows while checking the index, data, and stability under backpressure.
  // inj_cyc >= 0 injects a beat (optionally together with clr_err) on that cycle.
  // reset_row >= 0 asserts rst_n when that row is presented and returns.
  task automatic drain(input bit identity, input logic [7:0] cval, input bit bp,
                       input int inj_cyc, input bit inj_clr, input int reset_row,
                       input string tag);
    int           row = 0;
    int           cyc = 0;
    bit           held = 1'b0;
    logic [127:0] prev_data;
    logic [3:0]   prev_row;
    while (row < N && cyc < 200) begin
      if (row == reset_row) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_valid"}, 128'(out_valid), 128'd0);
        check({tag, "_rst_busy"}, 128'(busy), 128'd0);
        check({tag, "_rst_data"}, out_data, 128'd0);
        out_ready = 1'b0;
        return;
      end
      result_valid = (cyc == inj_cyc);
      clr_err      = inj_clr && (cyc == inj_cyc);
      if (cyc == inj_cyc) begin
        for (int r = 0; r < N; r++) result_in[r*AW +: AW] = 32'sd5000;
      end
      check($sformatf("%s_valid_c%0d", tag, cyc), 128'(out_valid), 128'd1);
      if (held) begin
        check($sformatf("%s_hold_data_c%0d", tag, cyc), out_data, prev_data);
        check($sformatf("%s_hold_row_c%0d", tag, cyc), 128'(out_row), 128'(prev_row));
      end
      out_ready = bp ? (cyc % 4 == 3) : 1'b1;
      if (out_ready) begin
        check($sformatf("%s_row%0d_idx", tag, row), 128'(out_row), 128'(row));
        check($sformatf("%s_row%0d_data", tag, row), out_data, exp_row(identity, row, cval));
        row++;
        held = 1'b0;
      end else begin
        prev_data = out_data;
        prev_row  = out_row;
        held      = 1'b1;
      end
      tick;
      cyc++;
    end
    result_valid = 1'b0;
    clr_err      = 1'b0;
    out_ready    = 1'b0;
    check({tag, "_handshakes"}, 128'(row), 128'(N));
    check({tag, "_done_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_done_busy"}, 128'(busy), 128'd0);
  endtask

  task automatic clear_err;
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    check("err_cleared", 128'(overflow_err), 128'd0);
  endtask

  initial begin
    result_in    = '0;
    result_valid = 1'b0;
    cfg_scale    = '0;
    cfg_shift    = '0;
    cfg_relu     = 1'b0;
    out_ready    = 1'b0;
    clr_err      = 1'b0;

    // Reset values.
    #3;
    check("rst_valid", 128'(out_valid), 128'd0);
    check("rst_row", 128'(out_row), 128'd0);
    check("rst_data", out_data, 128'd0);
    check("rst_err", 128'(overflow_err), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    #9 rst_n = 1'b1;
    tick;

    // Identity tile, always ready. out_ready is held high through capture and LOAD.
    out_ready = 1'b1;
    send_tile(1'b1, 32'sd0, 16'd1, 6'd0, 1'b0, 0);
    drain(1'b1, 8'h00, 1'b0, -1, 1'b0, -1, "ident");

    // Rounding: (3000+16)>>5 = 94, with 1-in-4 backpressure.
    send_tile(1'b0, 32'sd1000, 16'd3, 6'd5, 1'b0, 0);
    drain(1'b0, 8'd94, 1'b1, -1, 1'b0, -1, "bp94");
    check("bp94_no_err", 128'(overflow_err), 128'd0);

    // floor(-2984/32) = -94.
    send_tile(1'b0, -32'sd1000, 16'd3, 6'd5, 1'b0, 0);
    drain(1'b0, 8'hA2, 1'b0, -1, 1'b0, -1, "neg94");

    // ReLU zeroes the negative result.
    send_tile(1'b0, -32'sd1000, 16'd3, 6'd5, 1'b1, 0);
    drain(1'b0, 8'h00, 1'b0, -1, 1'b0, -1, "relu");

    // Saturation at both ends.
    send_tile(1'b0, -32'sd100000, 16'd1, 6'd0, 1'b0, 0);
    drain(1'b0, 8'h80, 1'b0, -1, 1'b0, -1, "satlo");
    send_tile(1'b0, 32'sd100000, 16'd1, 6'd0, 1'b0, 0);
    drain(1'b0, 8'h7f, 1'b0, -1, 1'b0, -1, "sathi");

    // Shift 63 acts as 47: ((2^31-1)*(2^16-1) + 2^46) >> 47 = 1.
    send_tile(1'b0, 32'sh7fffffff, 16'hffff, 6'd63, 1'b0, 0);
    drain(1'b0, 8'd1, 1'b0, -1, 1'b0, -1, "shclamp");

    // Gapped capture matches the ungapped identity. A beat injected in DRAIN
    // is dropped and sets the flag.
    send_tile(1'b1, 32'sd0, 16'd1, 6'd0, 1'b0, 2);
    drain(1'b1, 8'h00, 1'b0, 3, 1'b0, -1, "gap");
    check("gap_err_set", 128'(overflow_err), 128'd1);
    clear_err();

    // A drop in the same cycle as clr_err leaves the flag set.
    send_tile(1'b0, 32'sd1000, 16'd3, 6'd5, 1'b0, 0);
    drain(1'b0, 8'd94, 1'b0, 5, 1'b1, -1, "clrdrop");
    check("clrdrop_err_set", 128'(overflow_err), 128'd1);
    clear_err();

    // Reset while row 7 is presented abandons the tile.
    send_tile(1'b1, 32'sd0, 16'd1, 6'd0, 1'b0, 0);
    drain(1'b1, 8'h00, 1'b0, -1, 1'b0, 7, "rst7");
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("rst7_idle_valid%0d", i), 128'(out_valid), 128'd0);
      check($sformatf("rst7_idle_busy%0d", i), 128'(busy), 128'd0);
    end
    send_tile(1'b1, 32'sd0, 16'd1, 6'd0, 1'b0, 0);
    drain(1'b1, 8'h00, 1'b0, -1, 1'b0, -1, "post_rst");

    // Reset in the middle of a capture. The next tile starts again from column 0.
    cfg_scale = 16'd3;
    cfg_shift = 6'd5;
    cfg_relu  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < N; r++) result_in[r*AW +: AW] = 32'sd7777;
      result_valid = 1'b1;
      tick;
    end
    result_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("caprst_busy", 128'(busy), 128'd0);
    #3 rst_n = 1'b1;
    tick;
    send_tile(1'b0, 32'sd1000, 16'd3, 6'd5, 1'b0, 0);
    drain(1'b0, 8'd94, 1'b0, -1, 1'b0, -1, "post_caprst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: timed out");
    $fatal(1, "watchdog");
  end

endmodule
